alu_cmd_seq: RTL

Command sequencer that sits directly upstream of `alu`. It accepts ALU commands (function, operand A, operand B) over a valid/ready handshake and registers them onto the ALU's `i_f`/`i_a`/`i_b` inputs. One cycle later it captures the ALU's `o_y`/`o_c` into a response register and presents it over a second valid/ready handshake. It also rejects the unused function code 3'b011 and counts completed responses.

---
 rtl/alu_cmd_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_seq.sv
//==============================================================================
// Module      : alu_cmd_seq
// Description : Valid/ready command sequencer feeding a registered ALU stage and
//               returning captured results; optional flags via ALU_CMD_FLAGS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_cmd_seq #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [2:0]   i_cmd_f,
  input  logic [N-1:0] i_cmd_a,
  input  logic [N-1:0] i_cmd_b,
  output logic [N-1:0] o_alu_a,
  output logic [N-1:0] o_alu_b,
  output logic [2:0]   o_alu_f,
  input  logic [N-1:0] i_alu_y,
  input  logic         i_alu_c,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [N-1:0] o_rsp_y,
  output logic         o_rsp_c,
  output logic         o_rsp_err,
`ifdef ALU_CMD_FLAGS_EN
  output logic         o_rsp_z,
  output logic         o_rsp_n,
`endif
  output logic [15:0]  o_done_cnt
);

  localparam logic [2:0] C_F_ILLEGAL = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_cmd_ready;
  logic         w_accept;
  logic         w_illegal;
  logic         w_rsp_hs;

  logic [N-1:0] r_alu_a;
  logic [N-1:0] r_alu_b;
  logic [2:0]   r_alu_f;
  logic [N-1:0] r_rsp_y;
  logic         r_rsp_c;
  logic         r_rsp_err;
  logic [15:0]  r_done_cnt;

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready);
    w_accept    = i_cmd_valid && w_cmd_ready;
    w_illegal   = (i_cmd_f == C_F_ILLEGAL);
    w_rsp_hs    = (r_state == S_RESP) && i_rsp_ready;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_illegal ? S_RESP : S_EXEC;
      end
      S_EXEC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        // A response handshake may coincide with accepting the next command.
        if (w_accept)      w_next = w_illegal ? S_RESP : S_EXEC;
        else if (w_rsp_hs) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_f    <= '0;
      r_rsp_y    <= '0;
      r_rsp_c    <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      if (w_accept && !w_illegal) begin
        r_alu_a <= i_cmd_a;
        r_alu_b <= i_cmd_b;
        r_alu_f <= i_cmd_f;
      end
      if (w_accept && w_illegal) begin
        r_rsp_y   <= '0;
        r_rsp_c   <= 1'b0;
        r_rsp_err <= 1'b1;
      end else if (r_state == S_EXEC) begin
        r_rsp_y   <= i_alu_y;
        r_rsp_c   <= i_alu_c;
        r_rsp_err <= 1'b0;
      end
      if (w_rsp_hs) r_done_cnt <= r_done_cnt + 16'd1;
    end
  end

`ifdef ALU_CMD_FLAGS_EN
  logic r_rsp_z;
  logic r_rsp_n;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rsp_z <= 1'b0;
      r_rsp_n <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_rsp_z <= 1'b0;
      r_rsp_n <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_rsp_z <= (i_alu_y == '0);
      r_rsp_n <= i_alu_y[N-1];
    end
  end

  assign o_rsp_z = r_rsp_z;
  assign o_rsp_n = r_rsp_n;
`endif

  assign o_cmd_ready = w_cmd_ready;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_f     = r_alu_f;
  assign o_rsp_y     = r_rsp_y;
  assign o_rsp_c     = r_rsp_c;
  assign o_rsp_err   = r_rsp_err;
  assign o_done_cnt  = r_done_cnt;

endmodule

`default_nettype wire
